// File: rtl/luna_pkg.sv
// Shared Luna definitions: arbiter FSM encoding and requester IDs.
package luna_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int CTR_W = 8;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating wait-state counter for the memory arbiter.
// expired_o is high once the count has reached TIMEOUT.
module mem_timeout_ctr
  import luna_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(TIMEOUT);

  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Luna single-port memory arbiter shared by instruction fetch and data.
// Define MEM_ARB_RR_EN for round-robin ties instead of data-over-fetch.
module mem_arbiter
  import luna_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  arb_state_e state_q, state_d;

  logic              win_q, win_d;
  logic              grant;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              err_q, err_d;

  logic ctr_clr;
  logic ctr_en;
  logic expired;

`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;

  // On a tie the requester not granted last goes first.
  always_comb begin
    grant = d_req ? REQ_DATA : REQ_FETCH;
    if (i_req && d_req) begin
      grant = ~last_q;
    end
  end

  always_comb begin
    last_d = last_q;
    if ((state_q == IDLE) && (i_req || d_req)) begin
      last_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_DATA;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign grant = d_req ? REQ_DATA : REQ_FETCH;
`endif

  assign ctr_clr = (state_q != BUSY);
  assign ctr_en  = (state_q == BUSY) && !mem_ready;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (ctr_clr),
    .en_i     (ctr_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    re_d      = re_q;
    we_d      = we_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = '0;
    d_rdata_d = '0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = BUSY;
          win_d   = grant;
          if (grant == REQ_DATA) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            addr_d  = i_addr;
            wdata_d = '0;
            we_d    = 1'b0;
          end
          re_d = ~we_d;
        end
      end
      BUSY: begin
        // A ready on the expiry edge still completes normally.
        if (mem_ready || expired) begin
          state_d = RESP;
          re_d    = 1'b0;
          we_d    = 1'b0;
          err_d   = ~mem_ready;
          if (win_q == REQ_DATA) begin
            d_ack_d = 1'b1;
            if (mem_ready && re_q) begin
              d_rdata_d = mem_rdata;
            end
          end else begin
            i_ack_d = 1'b1;
            if (mem_ready) begin
              i_rdata_d = mem_rdata;
            end
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= REQ_FETCH;
      addr_q    <= '0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      re_q      <= re_d;
      we_q      <= we_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences
// and a randomized run against a transaction-level memory model.
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int T  = 4;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, i_rdata, d_rdata;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          i_ack, d_ack, err;
  logic          mem_re, mem_we, mem_ready, busy;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .busy     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0] mem [logic [AW-1:0]];

  // requester snapshot taken just before each edge
  logic          s_i_req, s_d_req, s_d_we, s_rst;
  logic [AW-1:0] s_i_addr, s_d_addr;
  logic [DW-1:0] s_d_wdata;

  // expected transaction outcome
  bit            exp_v;
  int            exp_cyc;
  bit            exp_who;
  bit            exp_err;
  logic [DW-1:0] exp_data;
  int            exp_scnt;
  bit            last_data;

  // memory device state
  bit dev_act;
  int dev_L, dev_w, dev_scnt;
  int force_L;

  typedef struct {
    bit            is_data;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            pre;
    logic [DW-1:0] pre_val;
    int            L;
    bit            e_err;
    logic [DW-1:0] e_data;
    int            e_lat;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [DW-1:0] rd(logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               nm, act, expv, cyc);
    end
  endtask

  task automatic model_grant();
    bit w, we;
    int L, k;
    logic [AW-1:0] a;
    chk("grant_has_req", {63'd0, s_i_req | s_d_req}, 64'd1);
    if (s_i_req && s_d_req) w = RR ? !last_data : 1'b1;
    else w = s_d_req;
    last_data = w;
    a  = w ? s_d_addr : s_i_addr;
    we = w && s_d_we;
    chk("grant_addr", mem_addr, a);
    chk("grant_strobes", {mem_re, mem_we}, {!we, we});
    if (we) chk("grant_wdata", mem_wdata, s_d_wdata);
    if (force_L >= 0) L = force_L;
    else if ($urandom_range(0, 3) == 0) L = $urandom_range(T, T + 2);
    else L = $urandom_range(0, T - 1);
    k = (L <= T) ? L : T;
    exp_v    = 1'b1;
    exp_cyc  = cyc + k + 1;
    exp_who  = w;
    exp_err  = (L > T);
    exp_scnt = k + 1;
    exp_data = (we || L > T) ? '0 : rd(a);
    if (we && L <= T) mem[a] = s_d_wdata;
    dev_act  = 1'b1;
    dev_w    = 0;
    dev_scnt = 0;
    dev_L    = L;
  endtask

  task automatic cycle();
    s_i_req   = i_req;
    s_d_req   = d_req;
    s_d_we    = d_we;
    s_i_addr  = i_addr;
    s_d_addr  = d_addr;
    s_d_wdata = d_wdata;
    s_rst     = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      chk("reset_zero", {63'd0, |{i_ack, d_ack, err, busy, mem_re, mem_we,
          i_rdata, d_rdata, mem_addr, mem_wdata}}, 64'd0);
      exp_v     = 1'b0;
      dev_act   = 1'b0;
      last_data = 1'b1;
    end else begin
      if (dev_act && !(mem_re || mem_we)) begin
        chk("strobe_len", dev_scnt, exp_scnt);
        dev_act = 1'b0;
      end
      if (!dev_act && (mem_re || mem_we)) model_grant();
      if (dev_act) dev_scnt++;
      chk("busy", {63'd0, busy}, {63'd0, exp_v});
      if (exp_v && cyc == exp_cyc) begin
        chk("ack", {i_ack, d_ack}, exp_who ? 2'b01 : 2'b10);
        chk("err", {63'd0, err}, {63'd0, exp_err});
        chk("rdata", exp_who ? d_rdata : i_rdata, exp_data);
        exp_v = 1'b0;
      end else begin
        chk("no_ack", {i_ack, d_ack, err}, 3'b000);
      end
    end
    if (dev_act) begin
      mem_ready = (dev_w == dev_L);
      mem_rdata = (mem_ready && mem_re) ? rd(mem_addr) : DW'($urandom);
      dev_w++;
    end else begin
      mem_ready = 1'($urandom % 2);
      mem_rdata = DW'($urandom);
    end
    if (i_ack) i_req = 1'b0;
    if (d_ack) d_req = 1'b0;
  endtask

  task automatic wait_ack(output int lat);
    int t0;
    t0  = cyc;
    lat = -1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (i_ack || d_ack) begin
        lat = cyc - t0;
        break;
      end
    end
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_wait: got no ack, expected one within 30 cycles");
    end
  endtask

  initial begin
    int lat;
    bit exp_ord[4];

    tbl[0] = '{0, 0, 16'h0040, 16'h0000, 1, 16'hBEEF, 0, 0, 16'hBEEF, 2};
    tbl[1] = '{1, 1, 16'h1234, 16'h00A5, 0, 16'h0000, 3, 0, 16'h0000, 5};
    tbl[2] = '{1, 0, 16'h1234, 16'h0000, 0, 16'h0000, 1, 0, 16'h00A5, 3};
    tbl[3] = '{0, 0, 16'h0100, 16'h0000, 1, 16'h7777, 5, 1, 16'h0000, 6};
    tbl[4] = '{1, 0, 16'h0200, 16'h0000, 1, 16'h1357, 4, 0, 16'h1357, 6};
    tbl[5] = '{1, 1, 16'h0300, 16'h1111, 1, 16'hCAFE, 9, 1, 16'h0000, 6};
    tbl[6] = '{0, 0, 16'h0300, 16'h0000, 0, 16'h0000, 2, 0, 16'hCAFE, 4};
    tbl[7] = '{1, 0, 16'h0000, 16'h0000, 1, 16'hFFFF, 0, 0, 16'hFFFF, 2};

    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    force_L = 0; last_data = 1'b1;
    exp_v = 1'b0; dev_act = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    for (int v = 0; v < 8; v++) begin
      if (tbl[v].pre) mem[tbl[v].addr] = tbl[v].pre_val;
      force_L = tbl[v].L;
      if (tbl[v].is_data) begin
        d_req = 1'b1; d_we = tbl[v].we;
        d_addr = tbl[v].addr; d_wdata = tbl[v].wdata;
      end else begin
        i_req = 1'b1; i_addr = tbl[v].addr;
      end
      wait_ack(lat);
      chk($sformatf("vec%0d_lat", v), lat, tbl[v].e_lat);
      chk($sformatf("vec%0d_ack", v), {i_ack, d_ack},
          tbl[v].is_data ? 2'b01 : 2'b10);
      chk($sformatf("vec%0d_err", v), {63'd0, err}, {63'd0, tbl[v].e_err});
      chk($sformatf("vec%0d_rdata", v),
          tbl[v].is_data ? d_rdata : i_rdata, tbl[v].e_data);
      cycle();
    end

    // simultaneous requesters, each re-requesting as soon as it is served
    exp_ord = RR ? '{0, 1, 0, 1} : '{1, 1, 1, 1};
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    force_L = 0;
    i_req = 1'b1; i_addr = 16'h0500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0600;
    for (int n = 0; n < 4; n++) begin
      wait_ack(lat);
      chk($sformatf("tie_order%0d", n), {63'd0, d_ack}, {63'd0, exp_ord[n]});
      i_req = 1'b1;
      d_req = 1'b1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    cycle();
    cycle();

    // reset during the second wait cycle of a never-ready read
    force_L = 9;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    cycle();
    cycle();
    chk("rst_seq_strobe", {mem_re, mem_we}, 2'b10);
    cycle();
    rst = 1'b1;
    cycle();
    chk("rst_seq_ack", {i_ack, d_ack}, 2'b00);
    rst = 1'b0;
    force_L = 1;
    wait_ack(lat);
    chk("rst_seq_lat", lat, 3);
    chk("rst_seq_data", d_rdata, 16'h1357);
    cycle();

    force_L = -1;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req  = 1'b1;
        i_addr = 16'h0010 + AW'($urandom_range(0, 7));
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom % 2);
        d_addr  = 16'h0010 + AW'($urandom_range(0, 7));
        d_wdata = DW'($urandom);
      end
      cycle();
    end
    rst = 1'b0;
    for (int c = 0; c < 40; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
